// File: rtl/mult_share_ctrl.sv
// Shares one LAT-cycle pipelined multiplier among NREQ requesters, with an in-order response FIFO protected by credits.
// Define MULT_SHARE_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mult_share_ctrl #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_hi,
  output logic [NREQ-1:0]      gnt,
  output logic [31:0]          m_a,
  output logic [31:0]          m_b,
  output logic                 m_s,
  input  logic [31:0]          m_c,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
);

  localparam int CW = $clog2(LAT + FIFO_DEPTH + 1) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [IDW-1:0]          winner;
  logic                    found;
  logic                    issue;
  logic [LAT-1:0]          tag_valid_reg;
  logic [LAT-1:0][IDW-1:0] tag_id_reg;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           fifo_count_reg, count_next;
  logic [PW-1:0]           wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [31:0]             mem_data [FIFO_DEPTH];
  logic [IDW-1:0]          mem_id   [FIFO_DEPTH];
  logic [31:0]             head_data_reg, head_data_next;
  logic [IDW-1:0]          head_id_reg, head_id_next;
  logic                    push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef MULT_SHARE_RR_EN
  // rr_ptr_reg holds the index where the next search starts
  logic [IDW-1:0] rr_ptr_reg;

  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else if (issue) begin
      rr_ptr_reg <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end
`else
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k]) begin
        found  = 1'b1;
        winner = IDW'(k);
      end
    end
  end
`endif

  // Credit counts everything in flight plus queued; a pop this cycle is not yet credited
  assign issue = !reset && found && ((inflight + fifo_count_reg) < CW'(FIFO_DEPTH));

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign gnt[gi] = issue && (winner == IDW'(gi));
    end
  endgenerate

  assign m_a = issue ? req_a[32*winner +: 32] : 32'd0;
  assign m_b = issue ? req_b[32*winner +: 32] : 32'd0;
  assign m_s = issue ? ~req_hi[winner] : 1'b1;

  // Tag shadow pipe; half selection is done by the multiplier, so only id travels here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid_reg <= '0;
      tag_id_reg    <= '0;
    end else begin
      tag_valid_reg[0] <= issue;
      tag_id_reg[0]    <= winner;
      for (int k = 1; k < LAT; k++) begin
        tag_valid_reg[k] <= tag_valid_reg[k-1];
        tag_id_reg[k]    <= tag_id_reg[k-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LAT; k++) begin
      inflight = inflight + CW'(tag_valid_reg[k]);
    end
  end

  assign push = tag_valid_reg[LAT-1];
  assign pop  = (fifo_count_reg != '0) && rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_reg] <= m_c;
      mem_id[wr_ptr_reg]   <= tag_id_reg[LAT-1];
    end
  end

  // Head registers track the entry that will be at the front next cycle
  always_comb begin
    rd_ptr_next    = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    count_next     = fifo_count_reg + CW'(push) - CW'(pop);
    head_data_next = head_data_reg;
    head_id_next   = head_id_reg;
    if (count_next != '0) begin
      if (fifo_count_reg == CW'(pop)) begin
        head_data_next = m_c;
        head_id_next   = tag_id_reg[LAT-1];
      end else begin
        head_data_next = mem_data[rd_ptr_next];
        head_id_next   = mem_id[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      head_data_reg  <= '0;
      head_id_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      rd_ptr_reg     <= rd_ptr_next;
      fifo_count_reg <= count_next;
      head_data_reg  <= head_data_next;
      head_id_reg    <= head_id_next;
    end
  end

  assign rsp_valid = (fifo_count_reg != '0);
  assign rsp_data  = head_data_reg;
  assign rsp_id    = head_id_reg;
  assign busy      = (inflight != '0) || rsp_valid;

endmodule
